// File: rtl/dsi_pkg.sv
// rtl/dsi_pkg.sv - shared DSI packet types, data-type codes and header field widths
package dsi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_FOOTER  = 2'd3
    } dsi_state_t;

    localparam logic [5:0] DT_DCS_SHORT_WR = 6'h05;
    localparam logic [5:0] DT_DCS_LONG_WR  = 6'h39;
    localparam logic [5:0] DT_NULL         = 6'h09;

    localparam int VC_W  = 2;
    localparam int DT_W  = 6;
    localparam int DI_W  = VC_W + DT_W;
    localparam int WC_W  = 16;
    localparam int ECC_W = 8;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc_calculator.sv
// rtl/crc_calculator.sv - byte-serial CRC-16 (x^16+x^12+x^5+1, LSB first) over up to four bytes per write
module crc_calculator
    import dsi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        data_write,
    input  logic [31:0] data_in,
    input  logic [1:0]  bytes_number,
    output logic [15:0] crc_output_sync
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Reflected table-free byte update: x folds the incoming byte with the low CRC byte.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [7:0] x;
        x = crc[7:0] ^ d;
        x = x ^ {x[3:0], 4'h0};
        return {8'h00, crc[15:8]} ^ {x, 8'h00} ^ {5'b00000, x, 3'b000} ^ {12'h000, x[7:4]};
    endfunction

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 4; i++) begin
            if (i <= int'(bytes_number)) begin
                crc_d = crc_byte(crc_d, data_in[8*i +: 8]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else if (clear) begin
            crc_q <= CRC_INIT;
        end else if (data_write) begin
            crc_q <= crc_d;
        end
    end

    assign crc_output_sync = crc_q;

endmodule

// File: rtl/dsi_pkt_out_reg.sv
// rtl/dsi_pkt_out_reg.sv - single-entry output word register with valid/ready handshake
module dsi_pkt_out_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [1:0]  load_bytes,
    input  logic        load_last,
    output logic        slot_free,
    output logic [31:0] out_data,
    output logic [1:0]  out_bytes,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= 32'h0;
            out_bytes <= 2'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_bytes <= load_bytes;
            out_last  <= load_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ecc_calc.sv
// rtl/ecc_calc.sv - DSI packet header ECC (6-bit Hamming code over the 24-bit header, P7/P6 zero)
module ecc_calc
    import dsi_pkg::*;
(
    input  logic [DI_W+WC_W-1:0] hdr,
    output logic [ECC_W-1:0]     ecc
);

    // Each mask selects the header bits covered by one parity bit P0..P5.
    assign ecc = {2'b00,
                  ^(hdr & 24'hEFFC00),
                  ^(hdr & 24'hDF03F0),
                  ^(hdr & 24'hB8E38E),
                  ^(hdr & 24'h749A6D),
                  ^(hdr & 24'hF2555B),
                  ^(hdr & 24'hF12CB7)};

endmodule

// File: rtl/dsi_packet_assembler.sv
// rtl/dsi_packet_assembler.sv - DSI packet builder: header+ECC, payload, CRC footer (CRC under DSI_PKT_CRC_EN)
module dsi_packet_assembler
    import dsi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic        pkt_long,
    input  logic [1:0]  pkt_vc,
    input  logic [5:0]  pkt_dt,
    input  logic [15:0] pkt_wc,
    input  logic [31:0] pld_data,
    input  logic        pld_valid,
    output logic        pld_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_bytes,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    dsi_state_t  state_q, state_d;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic        long_q;
    logic [15:0] rem_q;

    logic        slot_free;
    logic        load;
    logic [31:0] load_data;
    logic [1:0]  load_bytes;
    logic        load_last;
    logic        crc_clear;
    logic        crc_write;
    logic [15:0] crc_value;
    logic [7:0]  ecc;
    logic [1:0]  pld_bytes;

    ecc_calc u_ecc (
        .hdr (ebb_hdr()),
        .ecc (ecc)
    );

    function automatic logic [23:0] ebb_hdr();
        return {wc_q, di_q};
    endfunction

`ifdef DSI_PKT_CRC_EN
    crc_calculator u_crc (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear           (crc_clear),
        .data_write      (crc_write),
        .data_in         (pld_data),
        .bytes_number    (pld_bytes),
        .crc_output_sync (crc_value)
    );
`else
    // Footer reports "checksum not computed"; the strobes have no consumer in this build.
    logic crc_unused;
    assign crc_unused = crc_clear ^ crc_write;
    assign crc_value  = 16'h0000;
`endif

    dsi_pkt_out_reg u_out (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_data  (load_data),
        .load_bytes (load_bytes),
        .load_last  (load_last),
        .slot_free  (slot_free),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Valid bytes in the current payload word minus one; rem is never zero in PAYLOAD.
    assign pld_bytes = (rem_q >= 16'd4) ? 2'd3 : (rem_q[1:0] - 2'd1);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        pkt_ready  = 1'b0;
        pld_ready  = 1'b0;
        load       = 1'b0;
        load_data  = 32'h0;
        load_bytes = 2'd0;
        load_last  = 1'b0;
        crc_clear  = 1'b0;
        crc_write  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    crc_clear = 1'b1;
                    state_d   = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = {ecc, wc_q[15:8], wc_q[7:0], di_q};
                    load_bytes = 2'd3;
                    if (!long_q) begin
                        load_last = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (wc_q == 16'd0) begin
                        state_d = ST_FOOTER;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                pld_ready = slot_free;
                if (pld_valid && slot_free) begin
                    load       = 1'b1;
                    load_data  = pld_data;
                    load_bytes = pld_bytes;
                    crc_write  = 1'b1;
                    if (rem_q <= 16'd4) begin
                        state_d = ST_FOOTER;
                    end
                end
            end
            ST_FOOTER: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = {16'h0000, crc_value[15:8], crc_value[7:0]};
                    load_bytes = 2'd1;
                    load_last  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            di_q    <= 8'h0;
            wc_q    <= 16'h0;
            long_q  <= 1'b0;
            rem_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && pkt_valid) begin
                di_q   <= {pkt_vc, pkt_dt};
                wc_q   <= pkt_wc;
                long_q <= pkt_long;
                rem_q  <= pkt_wc;
            end else if (crc_write) begin
                rem_q <= rem_q - ({14'h0, pld_bytes} + 16'd1);
            end
        end
    end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// tb/tb_dsi_packet_assembler.sv - randomized self-checking bench for dsi_packet_assembler against a packet-level model
module tb_dsi_packet_assembler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pkt_valid, pkt_ready, pkt_long;
    logic [1:0]  pkt_vc;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic [31:0] pld_data;
    logic        pld_valid, pld_ready;
    logic [31:0] out_data;
    logic [1:0]  out_bytes;
    logic        out_last, out_valid, out_ready, busy;

    always #5 clk = ~clk;

    dsi_packet_assembler dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_long  (pkt_long),
        .pkt_vc    (pkt_vc),
        .pkt_dt    (pkt_dt),
        .pkt_wc    (pkt_wc),
        .pld_data  (pld_data),
        .pld_valid (pld_valid),
        .pld_ready (pld_ready),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  bytes;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] pld_q[$];
    logic [31:0] saved_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Syndrome contributed by each header bit D0..D23 (bit k of the code = parity Pk).
    localparam logic [5:0] ECC_CODE [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] model_ecc(input logic [23:0] h);
        logic [5:0] e;
        e = 6'h0;
        for (int i = 0; i < 24; i++) begin
            if (h[i]) e = e ^ ECC_CODE[i];
        end
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic fill_random(input logic [15:0] wc);
        pld_q.delete();
        for (int i = 0; i < (int'(wc) + 3) / 4; i++) pld_q.push_back($urandom);
    endtask

    task automatic build_expected(input logic lng, input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        logic [23:0] h;
        logic [7:0]  bytes_q[$];
        int          rem, take, idx;
        logic [15:0] crc;
        exp_q.delete();
        h = {wc, vc, dt};
        exp_q.push_back('{data: {model_ecc(h), h}, bytes: 2'd3, last: !lng});
        if (lng) begin
            rem = int'(wc);
            idx = 0;
            while (rem > 0) begin
                take = (rem < 4) ? rem : 4;
                exp_q.push_back('{data: pld_q[idx], bytes: 2'(take - 1), last: 1'b0});
                for (int k = 0; k < take; k++) bytes_q.push_back(pld_q[idx][8*k +: 8]);
                rem -= take;
                idx++;
            end
`ifdef DSI_PKT_CRC_EN
            crc = model_crc(bytes_q);
`else
            crc = 16'h0000;
`endif
            exp_q.push_back('{data: {16'h0000, crc}, bytes: 2'd1, last: 1'b1});
        end
    endtask

    // Runs one packet with the output compared word by word; abort_at >= 0 stops early for reset tests.
    task automatic send(input logic lng, input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                        input bit stall, input int abort_at);
        int    cyc;
        bit    req, hold;
        word_t prev, e;
        build_expected(lng, vc, dt, wc);
        pkt_long = lng; pkt_vc = vc; pkt_dt = dt; pkt_wc = wc;
        cyc = 0; req = 1'b1; hold = 1'b0; prev = '0;
        while (exp_q.size() > 0 && cyc < 2000 && cyc != abort_at) begin
            @(negedge clk);
            if (hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_word", {out_data, out_bytes, out_last}, prev);
            end
            pkt_valid = req;
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            pld_valid = (pld_q.size() > 0) && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
            pld_data  = (pld_q.size() > 0) ? pld_q[0] : 32'h0;
            #1;
            if (pkt_valid && pkt_ready) req = 1'b0;
            if (pld_valid && pld_ready) void'(pld_q.pop_front());
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_bytes", out_bytes, e.bytes);
                check("out_last", out_last, e.last);
            end
            hold = out_valid && !out_ready;
            prev = {out_data, out_bytes, out_last};
            cyc++;
        end
        if (abort_at < 0) check("packet_complete_in_budget", cyc < 2000, 1'b1);
        pkt_valid = 1'b0;
        pld_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; pkt_valid = 1'b0; pkt_long = 1'b0; pkt_vc = 2'd0; pkt_dt = 6'd0;
        pkt_wc = 16'd0; pld_data = 32'h0; pld_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_bytes", out_bytes, 2'd0);
        check("rst_pld_ready", pld_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_pkt_ready", pkt_ready, 1'b1);

        pld_q.delete();
        send(1'b0, 2'd0, 6'h05, 16'h0000, 1'b0, -1);
        send(1'b1, 2'd0, 6'h39, 16'h0000, 1'b0, -1);

        pld_q.delete();
        pld_q.push_back(32'h44332211);
        pld_q.push_back(32'h00006655);
        send(1'b1, 2'd0, 6'h39, 16'd6, 1'b0, -1);

        fill_random(16'd37);
        saved_q = pld_q;
        send(1'b1, 2'd1, 6'h39, 16'd37, 1'b0, -1);
        pld_q = saved_q;
        send(1'b1, 2'd1, 6'h39, 16'd37, 1'b1, -1);

        for (int i = 0; i < 4; i++) begin
            pld_q.delete();
            send(1'b0, 2'($urandom), 6'($urandom), 16'($urandom), 1'($urandom), -1);
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] wc;
            wc = 16'($urandom_range(1, 40));
            fill_random(wc);
            send(1'b1, 2'($urandom), 6'($urandom), wc, 1'($urandom), -1);
        end

        fill_random(16'd4);
        send(1'b1, 2'd2, 6'h39, 16'd4, 1'b0, -1);

        fill_random(16'd20);
        send(1'b1, 2'd3, 6'h39, 16'd20, 1'b0, 4);
        check("mid_payload_busy", busy, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pld_ready", pld_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pld_q.delete();
        pld_q.push_back(32'h44332211);
        pld_q.push_back(32'h00006655);
        send(1'b1, 2'd0, 6'h39, 16'd6, 1'b0, -1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
